// File: rtl/venom_pkg.sv
// Shared types and constants for the venom projectile controller.
// Contents: FSM state encoding, snake heading codes, default fire keycode.
// Imported by venom_key_edge and venom_fire_ctrl.
package venom_pkg;

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_FLIGHT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } venom_state_e;

  // Snake heading as presented on motionFlag and latched into bullet_dir.
  localparam logic [1:0] DIR_W = 2'b00;
  localparam logic [1:0] DIR_A = 2'b01;
  localparam logic [1:0] DIR_S = 2'b10;
  localparam logic [1:0] DIR_D = 2'b11;

  // Space bar scan code.
  localparam logic [7:0] VENOM_FIRE_KEY = 8'h2C;

endpackage

// File: rtl/venom_key_edge.sv
// Fire key rising-edge detector over two concurrent keycode bytes.
// Latency: fire_edge is combinational from keycode; key_prev is one frame behind.
// Backpressure: none; edges are presented once and never held.
// Ports: frame_clk/Reset (async, active-high), keycode[15:0] in,
//        key_prev (registered key level), fire_edge (press this frame).
module venom_key_edge
  import venom_pkg::*;
#(
  parameter logic [7:0] FIRE_KEY = VENOM_FIRE_KEY
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  output logic        key_prev,
  output logic        fire_edge
);

  logic key_match;

  // Either key slot may carry the fire key.
  assign key_match = (keycode[15:8] == FIRE_KEY) | (keycode[7:0] == FIRE_KEY);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      key_prev <= 1'b0;
    end else begin
      key_prev <= key_match;
    end
  end

  // A held key produces exactly one edge.
  assign fire_edge = key_match & ~key_prev;

endmodule

// File: rtl/venom_fire_ctrl.sv
// Venom projectile sequencer: launch on fire edge, flight, cooldown, ammo reload.
// Latency: one frame_clk edge from a sampled fire edge to launch/venom_active.
// Backpressure: none; fire edges outside READY or with no ammo are dropped.
// Ports: frame_clk/Reset (async, active-high); keycode, motionFlag, collision,
//        off_screen, game_active in; launch, venom_active, bullet_dir, ammo,
//        hit_pulse out (all registered).
module venom_fire_ctrl
  import venom_pkg::*;
#(
  parameter int         MAX_AMMO   = 3,
  parameter int         COOLDOWN   = 15,
  parameter int         FLIGHT_MAX = 213,
  parameter int         RELOAD     = 120,
  parameter logic [7:0] FIRE_KEY   = VENOM_FIRE_KEY
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic [1:0]  motionFlag,
  input  logic        collision,
  input  logic        off_screen,
  input  logic        game_active,
  output logic        launch,
  output logic        venom_active,
  output logic [1:0]  bullet_dir,
  output logic [1:0]  ammo,
  output logic        hit_pulse
);

  localparam logic [1:0] S_READY    = ST_READY;
  localparam logic [1:0] S_FLIGHT   = ST_FLIGHT;
  localparam logic [1:0] S_COOLDOWN = ST_COOLDOWN;

  localparam logic [1:0] AMMO_FULL   = 2'(MAX_AMMO);
  localparam logic [7:0] FLIGHT_LAST = 8'(FLIGHT_MAX - 1);
  localparam logic [7:0] COOL_LAST   = 8'(COOLDOWN - 1);
  localparam logic [7:0] RELOAD_LAST = 8'(RELOAD - 1);

  logic [1:0] state;
  logic [7:0] flight_cnt;
  logic [7:0] cool_cnt;
  logic [7:0] reload_cnt;
  logic       fire_edge;
  logic       unused_key_prev;   // sampled key level; the FSM only needs the edge
  logic       shot_go;
  logic       reload_done;

  venom_key_edge #(
    .FIRE_KEY (FIRE_KEY)
  ) u_key_edge (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .key_prev  (unused_key_prev),
    .fire_edge (fire_edge)
  );

  assign shot_go     = (state == S_READY) & fire_edge & game_active & (ammo != 2'd0);
  assign reload_done = game_active & (ammo < AMMO_FULL) & (reload_cnt == RELOAD_LAST);

  // Shot sequencing. Exit priority out of FLIGHT: game stop, hit, off-screen/timeout,
  // so a collision on the final flight frame still counts as a hit.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_READY;
      flight_cnt   <= 8'd0;
      cool_cnt     <= 8'd0;
      bullet_dir   <= DIR_W;
      launch       <= 1'b0;
      venom_active <= 1'b0;
      hit_pulse    <= 1'b0;
    end else begin
      launch    <= 1'b0;
      hit_pulse <= 1'b0;
      case (state)
        S_READY: begin
          if (shot_go) begin
            state        <= S_FLIGHT;
            bullet_dir   <= motionFlag;
            flight_cnt   <= 8'd0;
            launch       <= 1'b1;
            venom_active <= 1'b1;
          end
        end
        S_FLIGHT: begin
          flight_cnt <= flight_cnt + 8'd1;
          if (!game_active) begin
            state        <= S_READY;
            venom_active <= 1'b0;
          end else if (collision) begin
            state        <= S_COOLDOWN;
            cool_cnt     <= 8'd0;
            hit_pulse    <= 1'b1;
            venom_active <= 1'b0;
          end else if (off_screen || (flight_cnt == FLIGHT_LAST)) begin
            state        <= S_COOLDOWN;
            cool_cnt     <= 8'd0;
            venom_active <= 1'b0;
          end
        end
        S_COOLDOWN: begin
          cool_cnt <= cool_cnt + 8'd1;
          if (!game_active || (cool_cnt == COOL_LAST)) begin
            state <= S_READY;
          end
        end
        default: begin
          state        <= S_READY;
          venom_active <= 1'b0;
        end
      endcase
    end
  end

  // Ammo bookkeeping. A launch and a reload on the same edge cancel out,
  // while the reload counter still wraps.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      ammo       <= AMMO_FULL;
      reload_cnt <= 8'd0;
    end else begin
      if (shot_go && !reload_done) begin
        ammo <= ammo - 2'd1;
      end else if (reload_done && !shot_go) begin
        ammo <= ammo + 2'd1;
      end

      if (ammo == AMMO_FULL) begin
        reload_cnt <= 8'd0;
      end else if (reload_done) begin
        reload_cnt <= 8'd0;
      end else if (game_active) begin
        reload_cnt <= reload_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_venom_fire_ctrl.sv
// Self-checking bench for venom_fire_ctrl: a frame-level reference model pushes
// expected outputs into a queue each frame; they are popped and compared after the edge.
module tb_venom_fire_ctrl;
  import venom_pkg::*;

  localparam int T_AMMO   = 3;
  localparam int T_COOL   = 15;
  localparam int T_FLIGHT = 213;
  localparam int T_RELOAD = 120;

  logic        frame_clk;
  logic        Reset;
  logic [15:0] keycode;
  logic [1:0]  motionFlag;
  logic        collision;
  logic        off_screen;
  logic        game_active;
  logic        launch;
  logic        venom_active;
  logic [1:0]  bullet_dir;
  logic [1:0]  ammo;
  logic        hit_pulse;

  venom_fire_ctrl dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .motionFlag   (motionFlag),
    .collision    (collision),
    .off_screen   (off_screen),
    .game_active  (game_active),
    .launch       (launch),
    .venom_active (venom_active),
    .bullet_dir   (bullet_dir),
    .ammo         (ammo),
    .hit_pulse    (hit_pulse)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic       la;
    logic       va;
    logic [1:0] dir;
    logic [1:0] am;
    logic       hit;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;
  int n_launch, n_va, n_hit;

  // reference model state (0 ready, 1 flight, 2 cooldown)
  int m_st, m_ammo, m_dir, m_fc, m_cc, m_rc;
  bit m_kp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, ncyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ammo = T_AMMO; m_dir = 0; m_fc = 0; m_cc = 0; m_rc = 0; m_kp = 0;
  endtask

  // Expected outputs after the coming edge, given the inputs now applied.
  task automatic model_step();
    bit km, fe, go, rl, n_hit;
    int n_st, n_rc;
    exp_t e;
    km = (keycode[15:8] == 8'h2C) || (keycode[7:0] == 8'h2C);
    fe = km && !m_kp;
    go = (m_st == 0) && fe && game_active && (m_ammo > 0);
    rl = game_active && (m_ammo < T_AMMO) && (m_rc == T_RELOAD - 1);
    if (m_ammo == T_AMMO)  n_rc = 0;
    else if (!game_active) n_rc = m_rc;
    else if (rl)           n_rc = 0;
    else                   n_rc = m_rc + 1;
    n_hit = 0;
    n_st  = m_st;
    if (m_st == 0) begin
      if (go) begin n_st = 1; m_dir = motionFlag; m_fc = 0; end
    end else if (m_st == 1) begin
      if (!game_active)    n_st = 0;
      else if (collision) begin n_st = 2; n_hit = 1; m_cc = 0; end
      else if (off_screen || m_fc == T_FLIGHT - 1) begin n_st = 2; m_cc = 0; end
      else m_fc = m_fc + 1;
    end else begin
      if (!game_active || m_cc == T_COOL - 1) n_st = 0;
      else m_cc = m_cc + 1;
    end
    m_ammo = m_ammo - int'(go) + int'(rl);
    m_rc   = n_rc;
    m_st   = n_st;
    m_kp   = km;
    e.la  = go;
    e.va  = (n_st == 1);
    e.dir = 2'(m_dir);
    e.am  = 2'(m_ammo);
    e.hit = n_hit;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge frame_clk);
    #1;
    ncyc++;
    e = sb.pop_front();
    chk("launch",       {31'd0, launch},       {31'd0, e.la});
    chk("venom_active", {31'd0, venom_active}, {31'd0, e.va});
    chk("bullet_dir",   {30'd0, bullet_dir},   {30'd0, e.dir});
    chk("ammo",         {30'd0, ammo},         {30'd0, e.am});
    chk("hit_pulse",    {31'd0, hit_pulse},    {31'd0, e.hit});
    if (launch)       n_launch++;
    if (venom_active) n_va++;
    if (hit_pulse)    n_hit++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    Reset = 1'b0;
  endtask

  // One press, end the flight by off-screen, then let cooldown expire.
  task automatic quick_shot(input logic [1:0] dir);
    motionFlag = dir;
    keycode = 16'h002C; tick();
    keycode = 16'h0000;
    off_screen = 1'b1;  tick();
    off_screen = 1'b0;  ticks(T_COOL + 1);
  endtask

  int t0;
  int guard;

  initial begin
    Reset = 1'b1; keycode = 16'h0; motionFlag = DIR_W;
    collision = 1'b0; off_screen = 1'b0; game_active = 1'b0;
    do_reset();

    // reset state
    chk("rst_launch", {31'd0, launch},       32'd0);
    chk("rst_va",     {31'd0, venom_active}, 32'd0);
    chk("rst_dir",    {30'd0, bullet_dir},   32'd0);
    chk("rst_ammo",   {30'd0, ammo},         32'd3);
    chk("rst_hit",    {31'd0, hit_pulse},    32'd0);

    // first launch, then an uneventful full-length flight
    game_active = 1'b1; motionFlag = DIR_D; keycode = 16'h002C;
    n_va = 0; n_hit = 0;
    tick();
    chk("l1_launch", {31'd0, launch},       32'd1);
    chk("l1_va",     {31'd0, venom_active}, 32'd1);
    chk("l1_dir",    {30'd0, bullet_dir},   32'd3);
    chk("l1_ammo",   {30'd0, ammo},         32'd2);
    keycode = 16'h0000; motionFlag = DIR_A;
    ticks(240);
    chk("flight_len", n_va,  T_FLIGHT);
    chk("flight_hit", n_hit, 0);

    // held key fires once; presses in flight and cooldown are dropped
    n_launch = 0; motionFlag = DIR_S;
    keycode = 16'h2C00; ticks(10);
    chk("hold_once", n_launch, 1);
    keycode = 16'h0000; ticks(5);
    n_launch = 0;
    keycode = 16'h2C00; tick();
    keycode = 16'h0000; ticks(3);
    chk("flight_press", n_launch, 0);
    collision = 1'b1; n_hit = 0; tick();
    collision = 1'b0;
    chk("coll_va",  {31'd0, venom_active}, 32'd0);
    chk("coll_hit", {31'd0, hit_pulse},    32'd1);
    ticks(3);
    keycode = 16'h002C; tick();
    keycode = 16'h0000; ticks(11);
    chk("cool_press", n_launch, 0);
    chk("hit_once",   n_hit,    1);
    keycode = 16'h002C; tick();
    chk("after_cool", {31'd0, launch}, 32'd1);
    keycode = 16'h0000; off_screen = 1'b1; tick();
    off_screen = 1'b0; ticks(T_COOL + 2);

    // ammo exhaustion and reload
    do_reset();
    game_active = 1'b1;
    t0 = ncyc + 1;
    quick_shot(DIR_W);
    quick_shot(DIR_A);
    quick_shot(DIR_S);
    chk("empty_ammo", {30'd0, ammo}, 32'd0);
    n_launch = 0;
    keycode = 16'h002C; tick();
    keycode = 16'h0000; tick();
    chk("empty_press", n_launch, 0);
    while (ncyc < t0 + T_RELOAD - 1) tick();
    chk("pre_reload", {30'd0, ammo}, 32'd0);
    tick();
    chk("reload_1", {30'd0, ammo}, 32'd1);
    ticks(2 * T_RELOAD + 150);
    chk("reload_full", {30'd0, ammo}, 32'd3);

    // launch on the reload-completion edge with one venom left
    quick_shot(DIR_D);
    quick_shot(DIR_D);
    guard = 0;
    while (!(m_rc == T_RELOAD - 1 && m_st == 0 && m_ammo == 1) && guard < 400) begin
      tick();
      guard++;
    end
    chk("rl_sync_found", {31'd0, guard < 400}, 32'd1);
    motionFlag = DIR_A;
    keycode = 16'h002C; tick();
    keycode = 16'h0000;
    chk("rl_sync_launch", {31'd0, launch}, 32'd1);
    chk("rl_sync_ammo",   {30'd0, ammo},   32'd1);

    // game stops mid-flight
    ticks(4);
    n_hit = 0;
    game_active = 1'b0; tick();
    chk("stop_va",  {31'd0, venom_active}, 32'd0);
    chk("stop_hit", n_hit, 0);
    game_active = 1'b1; ticks(3);

    // asynchronous reset mid-flight
    keycode = 16'h002C; tick();
    keycode = 16'h0000; ticks(3);
    chk("pre_rst_va", {31'd0, venom_active}, 32'd1);
    Reset = 1'b1;
    #2;
    chk("arst_va",   {31'd0, venom_active}, 32'd0);
    chk("arst_ammo", {30'd0, ammo},         32'd3);
    model_reset();
    #1;
    Reset = 1'b0;
    motionFlag = DIR_S;
    keycode = 16'h2C2C; tick();
    keycode = 16'h0000; ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
